// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit sequencer.
// Holds the register map, the STATUS bit positions and the FSM encoding.
package uart_pkg;

  localparam logic [1:0] REG_CONTROL = 2'd0;
  localparam logic [1:0] REG_DATA_TX = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_DATA_RX = 2'd3;

  localparam int BUSY_BIT = 1;
  localparam int DONE_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_START    = 3'd2,
    ST_POLL_RD  = 3'd3,
    ST_POLL_CHK = 3'd4,
    ST_CLEAR    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Byte stream in, register-file access out, bundled for the UART transmit sequencer.
// slave = the sequencer's view; master = producer plus register-file side.
interface uart_tx_sequencer_if #(parameter int WIDTH = 8);

  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             rf_wr_en;
  logic [1:0]       rf_wr_addr;
  logic [WIDTH-1:0] rf_wr_data;
  logic             rf_rd_en;
  logic [1:0]       rf_rd_addr;
  logic [WIDTH-1:0] rf_rd_data;

  modport slave (
    input  s_valid, s_data, rf_rd_data,
    output s_ready, rf_wr_en, rf_wr_addr, rf_wr_data, rf_rd_en, rf_rd_addr
  );

  modport master (
    output s_valid, s_data, rf_rd_data,
    input  s_ready, rf_wr_en, rf_wr_addr, rf_wr_data, rf_rd_en, rf_rd_addr
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous byte FIFO with a registered "has room" flag.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // ready is registered so the producer sees 0 while reset is held
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      ready <= (count_nxt != (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Buffers stream bytes and runs one UART transmit per byte through the register file.
// Optional poll timeout is enabled by defining UART_SEQ_TIMEOUT_EN.
//
// state       | meaning
// IDLE        | wait for a queued byte, pop it into byte_q
// LOAD        | write byte_q to DATA_TX
// START       | write START_VAL to CONTROL, forget any earlier busy
// POLL_RD     | read STATUS
// POLL_CHK    | inspect STATUS, finish once done follows an observed busy
// CLEAR       | write 0 to CONTROL, report the byte as sent
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] START_VAL   = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                arst_n,
  uart_tx_sequencer_if.slave  bus,
  output logic                tx_sent,
  output logic                idle,
  output logic                err_timeout,
  input  logic                err_clr
);

  seq_state_t       state, state_nxt;
  logic [WIDTH-1:0] byte_q, byte_nxt, fifo_head;
  logic             seen_busy, seen_busy_nxt;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ready;
  logic             st_busy, st_done;
  logic             tmo_hit, tmo_take, tmo_flag;
  logic             wr_en_d, rd_en_d, tx_sent_d;
  logic [1:0]       wr_addr_d, rd_addr_d;
  logic [WIDTH-1:0] wr_data_d;
  logic             unused_rd_bits;

  assign bus.s_ready    = fifo_ready;
  assign fifo_push      = bus.s_valid && fifo_ready && !fifo_full;
  assign st_busy        = bus.rf_rd_data[BUSY_BIT];
  assign st_done        = bus.rf_rd_data[DONE_BIT];
  assign unused_rd_bits = ^bus.rf_rd_data;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .arst_n(arst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.s_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ready (fifo_ready)
  );

`ifdef UART_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          polling;

  assign polling = (state == ST_POLL_RD) || (state == ST_POLL_CHK);
  assign tmo_hit = polling && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // set has priority over a simultaneous err_clr
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tmo_cnt     <= '0;
      tmo_flag    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_START)  tmo_cnt <= '0;
      else if (polling)       tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_take)                tmo_flag <= 1'b1;
      else if (state == ST_CLEAR)  tmo_flag <= 1'b0;
      if (tmo_take)      err_timeout <= 1'b1;
      else if (err_clr)  err_timeout <= 1'b0;
    end
  end
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
  logic unused_tmo;

  assign tmo_hit     = 1'b0;
  assign tmo_flag    = 1'b0;
  assign err_timeout = 1'b0;
  assign unused_tmo  = tmo_take ^ err_clr;
`endif

  always_comb begin
    state_nxt     = state;
    byte_nxt      = byte_q;
    seen_busy_nxt = seen_busy;
    fifo_pop      = 1'b0;
    tmo_take      = 1'b0;
    wr_en_d       = 1'b0;
    wr_addr_d     = REG_CONTROL;
    wr_data_d     = '0;
    rd_en_d       = 1'b0;
    rd_addr_d     = REG_CONTROL;
    tx_sent_d     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          byte_nxt  = fifo_head;
          fifo_pop  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wr_en_d   = 1'b1;
        wr_addr_d = REG_DATA_TX;
        wr_data_d = byte_q;
        state_nxt = ST_START;
      end
      ST_START: begin
        wr_en_d       = 1'b1;
        wr_data_d     = START_VAL;
        seen_busy_nxt = 1'b0;
        state_nxt     = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        rd_en_d   = 1'b1;
        rd_addr_d = REG_STATUS;
        tmo_take  = tmo_hit;
        state_nxt = tmo_hit ? ST_CLEAR : ST_POLL_CHK;
      end
      ST_POLL_CHK: begin
        if (st_busy) seen_busy_nxt = 1'b1;
        // a done bit with no busy seen since START is left over from the last byte
        if ((seen_busy || st_busy) && st_done && !st_busy) begin
          state_nxt = ST_CLEAR;
        end else if (tmo_hit) begin
          tmo_take  = 1'b1;
          state_nxt = ST_CLEAR;
        end else begin
          state_nxt = ST_POLL_RD;
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        tx_sent_d = !tmo_flag;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // bus outputs are registered decodes of the current state
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state          <= ST_IDLE;
      byte_q         <= '0;
      seen_busy      <= 1'b0;
      bus.rf_wr_en   <= 1'b0;
      bus.rf_wr_addr <= '0;
      bus.rf_wr_data <= '0;
      bus.rf_rd_en   <= 1'b0;
      bus.rf_rd_addr <= '0;
      tx_sent        <= 1'b0;
      idle           <= 1'b1;
    end else begin
      state          <= state_nxt;
      byte_q         <= byte_nxt;
      seen_busy      <= seen_busy_nxt;
      bus.rf_wr_en   <= wr_en_d;
      bus.rf_wr_addr <= wr_addr_d;
      bus.rf_wr_data <= wr_data_d;
      bus.rf_rd_en   <= rd_en_d;
      bus.rf_rd_addr <= rd_addr_d;
      tx_sent        <= tx_sent_d;
      idle           <= (state == ST_IDLE) && fifo_empty;
    end
  end

endmodule
